// File: rtl/dcache_pkg.sv
// Purpose : shared types and address/merge helpers for the two-way data cache.
// Latency : n/a (package: pure functions, no state).
// Backpressure: n/a.
package dcache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VICTIM,
        ST_WRITEBACK,
        ST_FETCH,
        ST_FILL
    } state_e;

    // Set index: addr[off_w+idx_w-1:off_w], zero-extended to 32 bits.
    function automatic logic [31:0] addr_index(input logic [31:0] a, input int off_w, input int idx_w);
        return (a >> off_w) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    // Tag: addr[31:off_w+idx_w], right-justified.
    function automatic logic [31:0] addr_tag(input logic [31:0] a, input int off_w, input int idx_w);
        return a >> (off_w + idx_w);
    endfunction

    // Word select inside the line: addr[off_w-1:2].
    function automatic logic [31:0] addr_word(input logic [31:0] a, input int off_w);
        return (a >> 2) & ((32'd1 << (off_w - 2)) - 32'd1);
    endfunction

    // Byte-enabled merge of store data into an existing word.
    function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [31:0] dat,
                                               input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = dat[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dcache_2way_if.sv
// Purpose : pipeline-side (p1) and memory-side (mem) buses of the data cache.
// Latency : n/a (wiring only).
// Backpressure: p1 via p1_stall_o; mem via mem_enable_o held until mem_ack_i.
// p1 master = CPU MEM stage, slave = cache. mem master = cache, slave = memory.
interface dcache_p1_if;
    logic [31:0] p1_data_i;
    logic [3:0]  p1_be_i;
    logic [31:0] p1_addr_i;
    logic        p1_MemRead_i;
    logic        p1_MemWrite_i;
    logic [31:0] p1_data_o;
    logic        p1_stall_o;

    modport master (output p1_data_i, p1_be_i, p1_addr_i, p1_MemRead_i, p1_MemWrite_i,
                    input  p1_data_o, p1_stall_o);
    modport slave  (input  p1_data_i, p1_be_i, p1_addr_i, p1_MemRead_i, p1_MemWrite_i,
                    output p1_data_o, p1_stall_o);
endinterface

interface dcache_mem_if #(parameter int LINE_W = 256);
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;
    logic [LINE_W-1:0] mem_data_o;
    logic [31:0]       mem_addr_o;
    logic              mem_enable_o;
    logic              mem_write_o;

    modport master (input  mem_data_i, mem_ack_i,
                    output mem_data_o, mem_addr_o, mem_enable_o, mem_write_o);
    modport slave  (output mem_data_i, mem_ack_i,
                    input  mem_data_o, mem_addr_o, mem_enable_o, mem_write_o);
endinterface

// File: rtl/dcache_2way_way.sv
// Purpose : one cache way: per-set valid, dirty, tag and line storage.
// Latency : combinational read, write takes effect on the next rising edge.
// Backpressure: none; writes are accepted every cycle we_i is high.
// Ports: clk_i/rst_i; idx_i selects the set for both read and write;
//        we_i/wr_* write a line (always marks it valid); valid_o/dirty_o/tag_o/line_o read.
module dcache_way #(
    parameter int SETS   = 16,
    parameter int IDX_W  = 4,
    parameter int TAG_W  = 23,
    parameter int LINE_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic              we_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [LINE_W-1:0] wr_line_i,
    input  logic              wr_dirty_i,
    output logic              valid_o,
    output logic              dirty_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [LINE_W-1:0] line_o
);
    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [LINE_W-1:0] line_q [SETS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= wr_dirty_i;
        end
    end

    // Tag/data need no reset: they are meaningless while valid is clear.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[idx_i]  <= wr_tag_i;
            line_q[idx_i] <= wr_line_i;
        end
    end

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = line_q[idx_i];
endmodule

// File: rtl/dcache_2way_top.sv
// Purpose : two-way set-associative write-back/write-allocate data cache with LRU.
// Latency : hits complete in the request cycle; misses stall through victim/writeback/fetch/fill.
// Backpressure: p1_stall_o holds the CPU; mem requests stay up until mem_ack_i.
// Ports: clk_i/rst_i (sync, active high); p1 = CPU bus (slave); mem = line memory (master);
//        acc_cnt_o/miss_cnt_o = saturating completed-access and miss counters.
module dcache_2way_top
    import dcache_pkg::*;
#(
    parameter int SETS       = 16,
    parameter int LINE_BYTES = 32,
    parameter int CNT_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dcache_p1_if.slave       p1,
    dcache_mem_if.master     mem,
    output logic [CNT_W-1:0] acc_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int WSEL_W = OFF_W - 2;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [WSEL_W-1:0] wsel;

    assign idx  = IDX_W'(addr_index(p1.p1_addr_i, OFF_W, IDX_W));
    assign tag  = TAG_W'(addr_tag(p1.p1_addr_i, OFF_W, IDX_W));
    assign wsel = WSEL_W'(addr_word(p1.p1_addr_i, OFF_W));

    state_e            state_q;
    logic [SETS-1:0]   lru_q;
    logic              victim_q;
    logic              mem_en_q, mem_wr_q;
    logic [31:0]       mem_addr_q;
    logic [LINE_W-1:0] mem_data_q;
    logic [CNT_W-1:0]  acc_q, miss_q;

    logic [1:0]        way_vld, way_dty, way_hit, way_we;
    logic [TAG_W-1:0]  way_tag  [2];
    logic [LINE_W-1:0] way_line [2];
    logic [LINE_W-1:0] wr_line, hit_line;
    logic [31:0]       hit_word;
    logic              p1_req, hit, hit_way, hit_ok, store_hit, fill, vsel;

    assign p1_req    = p1.p1_MemRead_i | p1.p1_MemWrite_i;
    assign hit       = |way_hit;
    assign hit_way   = way_hit[1];
    assign hit_line  = way_line[hit_way];
    assign hit_word  = hit_line[wsel*32 +: 32];
    assign hit_ok    = p1_req & (state_q == ST_IDLE) & hit;
    assign store_hit = hit_ok & p1.p1_MemWrite_i;
    // Fill only counts while a fetch is actually outstanding; stray acks drop out here.
    assign fill      = (state_q == ST_FETCH) & mem_en_q & mem.mem_ack_i;
    // Prefer empty ways before evicting the LRU one.
    assign vsel      = ~way_vld[0] ? 1'b0 : (~way_vld[1] ? 1'b1 : lru_q[idx]);

    always_comb begin
        wr_line = hit_line;
        if (fill) begin
            wr_line = mem.mem_data_i;
        end else begin
            wr_line[wsel*32 +: 32] = merge_word(hit_word, p1.p1_data_i, p1.p1_be_i);
        end
    end

    for (genvar w = 0; w < 2; w++) begin : g_way
        assign way_hit[w] = way_vld[w] & (way_tag[w] == tag);
        assign way_we[w]  = (store_hit & (hit_way == 1'(w))) | (fill & (victim_q == 1'(w)));

        dcache_way #(.SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W), .LINE_W(LINE_W)) u_way (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .idx_i      (idx),
            .we_i       (way_we[w]),
            .wr_tag_i   (tag),
            .wr_line_i  (wr_line),
            .wr_dirty_i (~fill),
            .valid_o    (way_vld[w]),
            .dirty_o    (way_dty[w]),
            .tag_o      (way_tag[w]),
            .line_o     (way_line[w])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            lru_q      <= '0;
            victim_q   <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            acc_q      <= '0;
            miss_q     <= '0;
        end else begin
            if (hit_ok) begin
                lru_q[idx] <= ~hit_way;
                if (acc_q != '1) acc_q <= acc_q + 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (p1_req & ~hit) begin
                        state_q <= ST_VICTIM;
                        if (miss_q != '1) miss_q <= miss_q + 1'b1;
                    end
                end
                ST_VICTIM: begin
                    victim_q <= vsel;
                    mem_en_q <= 1'b1;
                    if (way_vld[vsel] & way_dty[vsel]) begin
                        state_q    <= ST_WRITEBACK;
                        mem_wr_q   <= 1'b1;
                        mem_addr_q <= {way_tag[vsel], idx, {OFF_W{1'b0}}};
                        mem_data_q <= way_line[vsel];
                    end else begin
                        state_q    <= ST_FETCH;
                        mem_wr_q   <= 1'b0;
                        mem_addr_q <= {tag, idx, {OFF_W{1'b0}}};
                    end
                end
                ST_WRITEBACK: begin
                    // Drop the request for a cycle; FETCH re-raises it with the fill address.
                    if (mem.mem_ack_i) begin
                        state_q  <= ST_FETCH;
                        mem_en_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (!mem_en_q) begin
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= {tag, idx, {OFF_W{1'b0}}};
                    end else if (mem.mem_ack_i) begin
                        mem_en_q <= 1'b0;
                        state_q  <= ST_FILL;
                    end
                end
                ST_FILL:  state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign p1.p1_stall_o  = p1_req & ~((state_q == ST_IDLE) & hit);
    assign p1.p1_data_o   = hit_ok ? hit_word : 32'd0;
    assign mem.mem_enable_o = mem_en_q;
    assign mem.mem_write_o  = mem_wr_q;
    assign mem.mem_addr_o   = mem_addr_q;
    assign mem.mem_data_o   = mem_data_q;
    assign acc_cnt_o  = acc_q;
    assign miss_cnt_o = miss_q;
endmodule

// File: tb/tb_dcache_2way_top.sv
// Purpose : directed self-checking bench for dcache_2way_top (SETS=16, 32-byte lines, 4-bit counters).
// Latency : memory model acks on the second cycle a request is seen high.
// Backpressure: CPU side waits on p1_stall_o with a cycle budget.
module tb_dcache_2way_top;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] acc_cnt, miss_cnt;

    always #5 clk = ~clk;

    dcache_p1_if p1 ();
    dcache_mem_if #(.LINE_W(256)) mem ();

    dcache_2way_top #(.SETS(16), .LINE_BYTES(32), .CNT_W(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .p1         (p1),
        .mem        (mem),
        .acc_cnt_o  (acc_cnt),
        .miss_cnt_o (miss_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Line memory model: 64 lines, addressed by addr[10:5].
    logic [255:0] mem_lines [64];
    logic         auto_ack, force_ack;
    logic [31:0]  req_addr [32];
    logic         req_wr   [32];
    int           req_gap  [32];
    logic [31:0]  req_w1   [32];
    int           nreq = 0;

    initial begin
        int dly, low;
        for (int l = 0; l < 64; l++)
            for (int w = 0; w < 8; w++)
                mem_lines[l][w*32 +: 32] = 32'hC000_0000 | (32'(l) << 8) | 32'(w);
        mem_lines[0][31:0]  = 32'h1111_1111;
        mem_lines[0][63:32] = 32'h1234_5678;
        mem.mem_ack_i  = 1'b0;
        mem.mem_data_i = '0;
        dly = 0;
        low = 0;
        forever begin
            @(negedge clk);
            mem.mem_ack_i = force_ack;
            if (mem.mem_enable_o) begin
                if (dly == 0 && nreq < 32) begin
                    req_addr[nreq] = mem.mem_addr_o;
                    req_wr[nreq]   = mem.mem_write_o;
                    req_gap[nreq]  = low;
                    req_w1[nreq]   = mem.mem_data_o[63:32];
                    nreq++;
                end
                low = 0;
                dly++;
                if (auto_ack && dly == 2) begin
                    mem.mem_ack_i = 1'b1;
                    if (mem.mem_write_o) mem_lines[mem.mem_addr_o[10:5]] = mem.mem_data_o;
                    else                 mem.mem_data_i = mem_lines[mem.mem_addr_o[10:5]];
                end
            end else begin
                dly = 0;
                low++;
            end
        end
    end

    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] dat,
                          input logic [3:0] be, output logic [31:0] rd, output int stalls);
        @(negedge clk);
        p1.p1_addr_i     = addr;
        p1.p1_data_i     = dat;
        p1.p1_be_i       = be;
        p1.p1_MemWrite_i = wr;
        p1.p1_MemRead_i  = ~wr;
        #1;
        stalls = 0;
        while (p1.p1_stall_o && stalls < 200) begin
            @(negedge clk);
            stalls++;
        end
        if (stalls >= 200) chk("stall_timeout", 64'(stalls), 64'd0);
        rd = p1.p1_data_o;
        @(posedge clk);
        #1;
        p1.p1_MemRead_i  = 1'b0;
        p1.p1_MemWrite_i = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not end, required completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int st, n;
        rst = 1'b1;
        auto_ack = 1'b1;
        force_ack = 1'b0;
        p1.p1_addr_i = '0; p1.p1_data_i = '0; p1.p1_be_i = '0;
        p1.p1_MemRead_i = 1'b0; p1.p1_MemWrite_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_stall", 64'(p1.p1_stall_o), 64'd0);
        chk("rst_data",  64'(p1.p1_data_o), 64'd0);
        chk("rst_en",    64'(mem.mem_enable_o), 64'd0);
        chk("rst_wr",    64'(mem.mem_write_o), 64'd0);
        chk("rst_addr",  64'(mem.mem_addr_o), 64'd0);
        chk("rst_acc",   64'(acc_cnt), 64'd0);
        chk("rst_miss",  64'(miss_cnt), 64'd0);

        // Cold miss on 0x000: IDLE,VICTIM,FETCH x2,FILL = 5 stall cycles.
        access(1'b0, 32'h000, 32'h0, 4'h0, rd, st);
        chk("rd000_data",  64'(rd), 64'h1111_1111);
        chk("rd000_stall", 64'(st), 64'd5);
        chk("rd000_maddr", 64'(req_addr[0]), 64'h000);
        chk("rd000_mwr",   64'(req_wr[0]), 64'd0);
        chk("rd000_acc",   64'(acc_cnt), 64'd1);
        chk("rd000_miss",  64'(miss_cnt), 64'd1);

        access(1'b0, 32'h200, 32'h0, 4'h0, rd, st);
        chk("rd200_data",  64'(rd), 64'hC000_1000);
        chk("rd200_stall", 64'(st), 64'd5);
        chk("rd200_maddr", 64'(req_addr[1]), 64'h200);

        access(1'b0, 32'h000, 32'h0, 4'h0, rd, st);
        chk("hit000_data",  64'(rd), 64'h1111_1111);
        chk("hit000_stall", 64'(st), 64'd0);
        access(1'b0, 32'h200, 32'h0, 4'h0, rd, st);
        chk("hit200_data",  64'(rd), 64'hC000_1000);
        chk("hit200_stall", 64'(st), 64'd0);
        chk("hits_miss",    64'(miss_cnt), 64'd2);
        chk("hits_acc",     64'(acc_cnt), 64'd4);

        // Partial store: low two bytes only.
        access(1'b1, 32'h004, 32'hAABB_CCDD, 4'b0011, rd, st);
        chk("st004_stall", 64'(st), 64'd0);
        access(1'b0, 32'h004, 32'h0, 4'h0, rd, st);
        chk("rd004_data",  64'(rd), 64'h1234_CCDD);
        chk("rd004_stall", 64'(st), 64'd0);

        // Touch 0x200 so dirty 0x000 is LRU, then evict it with 0x400.
        access(1'b0, 32'h200, 32'h0, 4'h0, rd, st);
        access(1'b0, 32'h400, 32'h0, 4'h0, rd, st);
        chk("rd400_data",  64'(rd), 64'hC000_2000);
        chk("rd400_stall", 64'(st), 64'd8);
        chk("wb_addr",     64'(req_addr[2]), 64'h000);
        chk("wb_wr",       64'(req_wr[2]), 64'd1);
        chk("wb_word1",    64'(req_w1[2]), 64'h1234_CCDD);
        chk("fetch_addr",  64'(req_addr[3]), 64'h400);
        chk("fetch_wr",    64'(req_wr[3]), 64'd0);
        chk("fetch_gap",   64'(req_gap[3]), 64'd1);
        chk("evict_miss",  64'(miss_cnt), 64'd3);
        chk("evict_acc",   64'(acc_cnt), 64'd8);
        access(1'b0, 32'h200, 32'h0, 4'h0, rd, st);
        chk("post_hit200_stall", 64'(st), 64'd0);
        chk("post_hit200_data",  64'(rd), 64'hC000_1000);

        // Reset in the middle of a fetch; the late ack must be ignored.
        auto_ack = 1'b0;
        @(negedge clk);
        p1.p1_addr_i = 32'h600;
        p1.p1_MemRead_i = 1'b1;
        n = 0;
        while (!mem.mem_enable_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mid_fetch_en",   64'(mem.mem_enable_o), 64'd1);
        chk("mid_fetch_addr", 64'(mem.mem_addr_o), 64'h600);
        rst = 1'b1;
        p1.p1_MemRead_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1 force_ack = 1'b1;
        @(negedge clk);
        #1 force_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("mid_rst_en",   64'(mem.mem_enable_o), 64'd0);
        chk("mid_rst_addr", 64'(mem.mem_addr_o), 64'd0);
        chk("mid_rst_acc",  64'(acc_cnt), 64'd0);
        chk("mid_rst_miss", 64'(miss_cnt), 64'd0);
        auto_ack = 1'b1;
        access(1'b0, 32'h200, 32'h0, 4'h0, rd, st);
        chk("rst_rd200_stall", 64'(st), 64'd5);
        chk("rst_rd200_data",  64'(rd), 64'hC000_1000);
        chk("rst_rd200_miss",  64'(miss_cnt), 64'd1);
        chk("rst_rd200_acc",   64'(acc_cnt), 64'd1);

        // Store with no byte enables leaves the line unchanged.
        access(1'b1, 32'h208, 32'hFFFF_FFFF, 4'b0000, rd, st);
        chk("be0_stall", 64'(st), 64'd0);
        access(1'b0, 32'h208, 32'h0, 4'h0, rd, st);
        chk("be0_data",  64'(rd), 64'hC000_1002);

        // 12 more hits bring acc to 15; one more must saturate.
        for (int i = 0; i < 12; i++) begin
            access(1'b0, 32'h200, 32'h0, 4'h0, rd, st);
            chk("sat_hit_stall", 64'(st), 64'd0);
        end
        chk("sat_acc_full", 64'(acc_cnt), 64'hF);
        access(1'b0, 32'h200, 32'h0, 4'h0, rd, st);
        chk("sat_acc_hold", 64'(acc_cnt), 64'hF);
        chk("sat_miss",     64'(miss_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
